// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory port between fetch and load/store,
// with load/store priority and a starvation guard that forces fetch through.
module mem_arbiter #(
    parameter int LATENCY    = 4,
    parameter int STARVE_MAX = 3,
    parameter int AW         = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ready,
    output logic [31:0]   if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [31:0]   ls_wdata,
    input  logic [3:0]    ls_be,
    output logic          ls_ready,
    output logic [31:0]   ls_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic [31:0]   mem_rdata,
    output logic          owner,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d, streak_q, streak_d, be_q, be_d;
    logic          we_q, we_d, owner_q, owner_d, ls_win, act;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d, if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;

    // fetch only wins a contested slot once load/store has taken STARVE_MAX in a row
    assign ls_win = ls_req && !(if_req && streak_q == 4'(STARVE_MAX));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        streak_d   = streak_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        owner_d    = owner_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        case (state_q)
            IDLE: if (if_req || ls_req) begin
                state_d  = BUSY;
                cnt_d    = 4'(LATENCY - 1);
                owner_d  = ls_win;
                we_d     = ls_win && ls_we;
                addr_d   = ls_win ? ls_addr : if_addr;
                wdata_d  = ls_win ? ls_wdata : '0;
                be_d     = (ls_win && ls_we) ? ls_be : 4'hF;
                streak_d = (ls_win && if_req) ? streak_q + 4'd1 : '0;
            end
            BUSY: if (cnt_q == '0) begin
                state_d = DONE;
                if (!owner_q) if_rdata_d = mem_rdata;
                else if (!we_q) ls_rdata_d = mem_rdata;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            streak_q   <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            owner_q    <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            streak_q   <= streak_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            owner_q    <= owner_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign act       = state_q == BUSY;
    assign mem_en    = act;
    assign mem_we    = act && we_q;
    assign mem_addr  = act ? addr_q : '0;
    assign mem_wdata = act ? wdata_q : '0;
    assign mem_be    = act ? be_q : '0;
    assign owner     = owner_q;
    assign busy      = state_q != IDLE;
    assign if_ready  = state_q == DONE && !owner_q;
    assign ls_ready  = state_q == DONE && owner_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter (LATENCY=4/STARVE_MAX=2
// instance with a small byte-writable memory, plus a LATENCY=1 instance).
module tb_mem_arbiter;
    logic        clk = 0, reset = 1;
    logic        if_req = 0, ls_req = 0, ls_we = 0;
    logic [31:0] if_addr = 0, ls_addr = 0, ls_wdata = 0;
    logic [3:0]  ls_be = 0;
    logic        if_ready, ls_ready, mem_en, mem_we, owner, busy;
    logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        b_if_req = 0;
    logic [31:0] b_if_addr = 32'h40;
    logic        b_if_ready, b_ls_ready, b_mem_en, b_mem_we, b_owner, b_busy;
    logic [31:0] b_if_rdata, b_ls_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [3:0]  b_mem_be;
    logic [31:0] mem [16];
    int          errors = 0, checks = 0;

    typedef struct packed {logic ls; logic [31:0] d;} exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    mem_arbiter #(.LATENCY(4), .STARVE_MAX(2), .AW(32)) dut (
        .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_rdata(if_rdata), .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_be(ls_be), .ls_ready(ls_ready), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .owner(owner), .busy(busy));

    mem_arbiter #(.LATENCY(1), .STARVE_MAX(3), .AW(32)) dut_b (
        .clk(clk), .reset(reset), .if_req(b_if_req), .if_addr(b_if_addr), .if_ready(b_if_ready),
        .if_rdata(b_if_rdata), .ls_req(1'b0), .ls_we(1'b0), .ls_addr(32'h0),
        .ls_wdata(32'h0), .ls_be(4'h0), .ls_ready(b_ls_ready), .ls_rdata(b_ls_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_be(b_mem_be), .mem_rdata(b_mem_rdata), .owner(b_owner), .busy(b_busy));

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hC0DE0000 | i;
            mem[0] <= 32'hDEADBEEF;
            mem[8] <= 32'hA5A5A5A5;
        end else if (mem_en && mem_we) begin
            for (int j = 0; j < 4; j++)
                if (mem_be[j]) mem[mem_addr[5:2]][8*j +: 8] <= mem_wdata[8*j +: 8];
        end
    end
    assign mem_rdata   = mem[mem_addr[5:2]];
    assign b_mem_rdata = b_mem_addr ^ 32'h5A5A5A5A;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (if_ready || ls_ready) begin
            if (q.size() == 0) chk("unexpected_ready", {if_ready, ls_ready}, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("ready_owner", {31'b0, ls_ready}, {31'b0, e.ls});
                chk("ready_excl", {31'b0, if_ready && ls_ready}, 0);
                chk("owner", {31'b0, owner}, {31'b0, e.ls});
                chk("rdata", e.ls ? ls_rdata : if_rdata, e.d);
            end
        end
    end

    task automatic wait_rdy(input logic [31:0] ea, input logic [3:0] eb,
                            output int k_rdy, output int en_n, output int we_n, output int bad);
        k_rdy = -1; en_n = 0; we_n = 0; bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_en) begin
                en_n++;
                if (mem_we) we_n++;
                if (mem_addr != ea || mem_be != eb) bad++;
            end
            if (if_ready || ls_ready) begin
                k_rdy = k;
                break;
            end
        end
    endtask

    initial begin
        int kr, en, wn, bad;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_en", {31'b0, mem_en}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_ready", {if_ready, ls_ready}, 0);
        chk("rst_rdata", if_rdata | ls_rdata, 0);
        chk("rst_mem_bus", mem_addr | mem_wdata | {28'b0, mem_be}, 0);
        @(posedge clk) #1 reset = 0;

        if_req = 1; if_addr = 32'h100;
        q.push_back('{ls: 1'b0, d: 32'hDEADBEEF});
        wait_rdy(32'h100, 4'hF, kr, en, wn, bad);
        chk("fetch_lat", kr, 5);
        chk("fetch_en_cycles", en, 4);
        chk("fetch_fields", bad, 0);
        @(posedge clk) #1 if_req = 0;

        ls_req = 1; ls_we = 1; ls_addr = 32'h20; ls_wdata = 32'h12345678; ls_be = 4'b0011;
        q.push_back('{ls: 1'b1, d: 32'h0});
        wait_rdy(32'h20, 4'b0011, kr, en, wn, bad);
        chk("store_lat", kr, 5);
        chk("store_we_cycles", wn, 4);
        chk("store_fields", bad, 0);
        @(posedge clk) #1 ls_we = 0;
        q.push_back('{ls: 1'b1, d: 32'hA5A55678});
        wait_rdy(32'h20, 4'hF, kr, en, wn, bad);
        chk("load_lat", kr, 5);
        chk("load_we_cycles", wn, 0);
        chk("load_fields", bad, 0);

        ls_addr = 32'h08;
        q.push_back('{ls: 1'b1, d: 32'hC0DE0002});
        q.push_back('{ls: 1'b1, d: 32'hC0DE0002});
        wait_rdy(32'h08, 4'hF, kr, en, wn, bad);
        wait_rdy(32'h08, 4'hF, kr, en, wn, bad);
        chk("held_spacing", kr + 1, 6);

        if_addr = 32'h104;
        for (int g = 0; g < 6; g++)
            q.push_back('{ls: (g % 3 != 2), d: (g % 3 != 2) ? 32'hC0DE0002 : 32'hC0DE0001});
        @(posedge clk) #1 if_req = 1;
        for (int g = 0; g < 6; g++) begin
            wait_rdy((g % 3 != 2) ? 32'h08 : 32'h104, 4'hF, kr, en, wn, bad);
            chk("starve_lat", kr, 5);
            chk("starve_fields", bad, 0);
        end
        @(posedge clk) #1 begin if_req = 0; ls_req = 0; end

        if_req = 1;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", {31'b0, busy}, 1);
        @(posedge clk) #1 begin reset = 1; if_req = 0; end
        @(posedge clk) #1 reset = 0;
        @(negedge clk);
        chk("mid_rst_mem_en", {31'b0, mem_en}, 0);
        chk("mid_rst_busy", {31'b0, busy}, 0);
        chk("mid_rst_rdata", if_rdata | ls_rdata, 0);
        chk("mid_rst_bus", mem_addr | {28'b0, mem_be} | {31'b0, owner}, 0);
        repeat (8) @(negedge clk);
        @(posedge clk) #1 begin if_req = 1; if_addr = 32'h100; end
        q.push_back('{ls: 1'b0, d: 32'hDEADBEEF});
        wait_rdy(32'h100, 4'hF, kr, en, wn, bad);
        chk("fresh_fetch_lat", kr, 5);
        @(posedge clk) #1 if_req = 0;

        b_if_req = 1;
        kr = -1; en = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (b_mem_en) en++;
            if (b_if_ready) begin kr = k; break; end
        end
        chk("l1_lat", kr, 2);
        chk("l1_en_cycles", en, 1);
        chk("l1_rdata", b_if_rdata, 32'h5A5A5A1A);
        kr = -1;
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            if (b_if_ready) begin kr = k; break; end
        end
        chk("l1_spacing", kr, 3);
        @(posedge clk) #1 b_if_req = 0;

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port data-memory arbiter and access sequencer for the core. It shares one multi-cycle, fixed-latency memory port between the instruction-fetch requester and the load/store unit. It latches the winning request, holds the memory strobes for the full access latency, and returns read data with a one-cycle ready pulse. Load/store has priority, with a starvation guard so fetch always makes progress.

## Interface
Parameters:
- LATENCY, 4: memory access cycles with strobes held; legal range 1..15.
- STARVE_MAX, 3: consecutive load/store grants taken while fetch was waiting before fetch is forced through; legal range 1..15.
- AW, 32: address width.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  AW  fetch address; stable while if_req=1.
- if_ready  out  1  one-cycle pulse: fetch access complete.
- if_rdata  out  32  fetched word; valid when if_ready=1 and held until the next fetch completes.
- ls_req  in  1  load/store request; held until ls_ready.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  AW  load/store address.
- ls_wdata  in  32  store data.
- ls_be  in  4  store byte enables.
- ls_ready  out  1  one-cycle pulse: load/store complete.
- ls_rdata  out  32  load word; updated only by loads.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  32  memory write data.
- mem_be  out  4  memory byte enables; 4'b1111 for fetch and for loads.
- mem_rdata  in  32  memory read data; valid in the last access cycle.
- owner  out  1  0 = fetch, 1 = load/store; meaningful while busy=1.
- busy  out  1  1 in BUSY and DONE.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE, no request: stay in IDLE. All mem_* outputs are 0.
- IDLE, request present: arbitrate, latch the winner's fields into the mem_* registers and owner, load the counter with LATENCY-1, and go to BUSY.
- Arbitration:
  - Only one requester: that requester wins.
  - Both requesting and streak < STARVE_MAX: load/store wins.
  - Both requesting and streak == STARVE_MAX: fetch wins.
- Streak counter:
  - Increments on a load/store grant while if_req=1.
  - Clears on any fetch grant, and on a load/store grant with if_req=0.
  - Saturates at STARVE_MAX.
- BUSY: mem_en=1. mem_we, mem_addr, mem_wdata, mem_be, owner are held constant; mem_we=1 only for stores. The counter decrements each cycle.
- BUSY exit: when the counter is 0, capture mem_rdata into if_rdata (owner=0) or ls_rdata (owner=1, load only), then go to DONE.
- DONE: mem_* outputs go to 0. The owner's ready output is 1 for exactly this cycle. Requests are ignored. Next state is IDLE.
- A requester samples ready=1 at the DONE edge and drops or changes req for the following IDLE cycle. A req still high in IDLE is a new access.
- Requests raised during BUSY/DONE are sampled only in IDLE.
- Stores: ls_rdata is unchanged.

## Timing
- Reset values:
  - State IDLE; counter 0; streak 0.
  - mem_en, mem_we, mem_addr, mem_wdata, mem_be all 0.
  - if_ready, ls_ready, if_rdata, ls_rdata all 0.
  - owner 0; busy 0.
- Grant sampled at IDLE cycle t.
  - mem_en=1 in cycles t+1 .. t+LATENCY.
  - mem_rdata sampled at the end of cycle t+LATENCY.
  - ready=1 and rdata valid in cycle t+LATENCY+1.
  - Back in IDLE at t+LATENCY+2.
- Throughput: one access per LATENCY+2 cycles.
- LATENCY=1: a single BUSY cycle, with the counter loaded with 0.
- Reset asserted mid-access (BUSY or DONE): next cycle is IDLE with reset values. No ready pulse is issued, the access is abandoned, and rdata registers clear.
- Reset has priority over all other events in the same cycle.

## Test plan
- Fetch alone, LATENCY=4:
  - Stimulus: if_req=1, if_addr=0x100, memory returns 0xDEADBEEF.
  - Required: mem_en high 4 cycles with mem_addr=0x100 and mem_be=4'hF; if_ready one pulse 5 cycles after the grant cycle; if_rdata=0xDEADBEEF.
- Store then load:
  - Stimulus: ls_we=1, ls_addr=0x20, ls_wdata=0x12345678, ls_be=4'b0011; then a load from 0x20.
  - Required: mem_we=1 only during store BUSY; ls_rdata stays 0 after the store and equals the memory value after the load.
- Simultaneous requests, STARVE_MAX=2, both held high:
  - Required grant order: LS, LS, IF, LS, LS, IF.
  - Required: owner matches each grant; only the owner's ready pulses.
- Held request:
  - Stimulus: ls_req kept high through DONE.
  - Required: a second access starts in the next IDLE cycle; 6-cycle spacing between ls_ready pulses at LATENCY=4.
- Reset mid-access: assert reset in the 2nd BUSY cycle.
  - Required: no ready pulse, mem_en=0 next cycle, all outputs 0.
  - Required: a fresh fetch afterwards completes normally.
- LATENCY=1:
  - Required: mem_en high 1 cycle, ready 2 cycles after the grant, 3-cycle back-to-back spacing.
